// File: rtl/hcount_gen_pkg.sv
// Shared video-timing constants and helpers for the horizontal and vertical counters.
package hcount_gen_pkg;

  localparam int CNT_W      = 9;
  localparam int SLICE_W    = 4;
  localparam int NUM_SLICES = 3;
  localparam int CHAIN_W    = SLICE_W * NUM_SLICES;

  localparam logic [CNT_W-1:0] LOAD_VAL_DEF = 9'h080;
  localparam logic [CNT_W-1:0] HB_START_DEF = 9'h1D0;
  localparam logic [CNT_W-1:0] HB_END_DEF   = 9'h090;
  localparam logic [CNT_W-1:0] HS_START_DEF = 9'h1E0;
  localparam logic [CNT_W-1:0] HS_END_DEF   = 9'h1F0;
  localparam logic [CNT_W-1:0] TERM_CNT     = 9'h1FF;

  // Next value of a start/end flag given the count it is about to take.
  // Start is tested first so that start == end leaves the flag set.
  function automatic logic flag_next(input logic cur,
                                     input logic [CHAIN_W-1:0] n,
                                     input logic [CNT_W-1:0] start,
                                     input logic [CNT_W-1:0] stop);
    logic res;
    res = cur;
    if (n == {{(CHAIN_W-CNT_W){1'b0}}, start}) begin
      res = 1'b1;
    end else if (n == {{(CHAIN_W-CNT_W){1'b0}}, stop}) begin
      res = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/hcount_gen_slice.sv
// 4-bit loadable synchronous up-counter slice with ripple carry in/out.
// The next-state value is exported so the parent can look ahead at the
// count it is about to take without duplicating the adder.
module hcnt_slice
  import hcount_gen_pkg::*;
(
  input  logic               clock,
  input  logic               ld,
  input  logic               ci,
  input  logic [SLICE_W-1:0] d,
  output logic [SLICE_W-1:0] q,
  output logic [SLICE_W-1:0] nxt,
  output logic               co
);

  // Load has priority over counting; without a carry in the slice holds.
  always_comb begin
    nxt = q;
    if (ld) begin
      nxt = d;
    end else if (ci) begin
      nxt = q + 4'd1;
    end
  end

  assign co = ci & (&q);

  // Slice state register.
  always_ff @(posedge clock) begin
    q <= nxt;
  end

endmodule

// File: rtl/hcount_gen.sv
// Horizontal pixel counter with blank/sync flags and a line-end pulse that
// feeds the vertical counter. Counter is a chain of three 4-bit slices; the
// upper three chain bits stay zero because the count never passes 0x1FF.
module hcount_gen
  import hcount_gen_pkg::*;
#(
  parameter logic [CNT_W-1:0] LOAD_VAL = LOAD_VAL_DEF,
  parameter logic [CNT_W-1:0] HB_START = HB_START_DEF,
  parameter logic [CNT_W-1:0] HB_END   = HB_END_DEF,
  parameter logic [CNT_W-1:0] HS_START = HS_START_DEF,
  parameter logic [CNT_W-1:0] HS_END   = HS_END_DEF
) (
  input  logic             CK,
  input  logic             CL,
  input  logic             EN,
  input  logic             LD,
  input  logic [CNT_W-1:0] D,
  output logic [CNT_W-1:0] HCNT,
  output logic             HBLANK,
  output logic             HSYNC,
  output logic             LE
);

  logic [CHAIN_W-1:0]  cnt;
  logic [CHAIN_W-1:0]  cntNxt;
  logic [CHAIN_W-1:0]  loadVal;
  logic [NUM_SLICES:0] carry;
  logic                atTerm;
  logic                wrap;
  logic                load;

  // Terminal detect covers the whole chain; a carry out of the top slice can
  // only come from a corrupted state and is treated as a wrap to recover.
  assign atTerm  = (cnt == {{(CHAIN_W-CNT_W){1'b0}}, TERM_CNT});
  assign wrap    = EN & (atTerm | carry[NUM_SLICES]);
  assign load    = CL | LD | wrap;
  assign loadVal = (LD & ~CL) ? {{(CHAIN_W-CNT_W){1'b0}}, D}
                              : {{(CHAIN_W-CNT_W){1'b0}}, LOAD_VAL};
  assign carry[0] = EN;

  genvar i;
  generate
    for (i = 0; i < NUM_SLICES; i++) begin : gSlice
      hcnt_slice uSlice (
        .clock (CK),
        .ld    (load),
        .ci    (carry[i]),
        .d     (loadVal[i*SLICE_W +: SLICE_W]),
        .q     (cnt[i*SLICE_W +: SLICE_W]),
        .nxt   (cntNxt[i*SLICE_W +: SLICE_W]),
        .co    (carry[i+1])
      );
    end
  endgenerate

  assign HCNT = cnt[CNT_W-1:0];

  // Flags follow the count the chain is about to take, so they line up with
  // HCNT in the same cycle; they only move on edges that count or load.
  always_ff @(posedge CK) begin
    if (CL) begin
      HBLANK <= 1'b1;
      HSYNC  <= 1'b0;
      LE     <= 1'b0;
    end else begin
      LE <= ~LD & wrap;
      if (LD | EN) begin
        HBLANK <= flag_next(HBLANK, cntNxt, HB_START, HB_END);
        HSYNC  <= flag_next(HSYNC,  cntNxt, HS_START, HS_END);
      end
    end
  end

endmodule

// File: tb/tb_hcount_gen.sv
// Scoreboard bench for hcount_gen: stimulus pushes expected outputs, a
// negedge monitor pops and compares them against two DUT instances.
module tb_hcount_gen;

  logic       clk = 1'b0;
  logic       CL  = 1'b1;
  logic       EN  = 1'b0;
  logic       LD  = 1'b0;
  logic [8:0] D   = 9'h000;

  logic [8:0] hcnt, hcnt2;
  logic       hblank, hblank2, hsync, hsync2, le, le2;

  typedef struct {
    logic [8:0] hcnt;
    logic       hblank;
    logic       hsync;
    logic       le;
    string      tag;
  } exp_t;

  exp_t expQ[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] mH;
  logic       mHb, mHs, mLe;

  always #5 clk = ~clk;

  hcount_gen dut (
    .CK(clk), .CL(CL), .EN(EN), .LD(LD), .D(D),
    .HCNT(hcnt), .HBLANK(hblank), .HSYNC(hsync), .LE(le)
  );

  hcount_gen #(.HB_START(9'h100), .HB_END(9'h100)) dut2 (
    .CK(clk), .CL(CL), .EN(EN), .LD(LD), .D(D),
    .HCNT(hcnt2), .HBLANK(hblank2), .HSYNC(hsync2), .LE(le2)
  );

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic cl, input logic ld, input logic en,
                               input logic [8:0] d, input logic [8:0] eh,
                               input logic eb, input logic es, input logic el,
                               input string tag);
    exp_t x;
    #1;
    CL = cl; LD = ld; EN = en; D = d;
    @(posedge clk);
    x.hcnt = eh; x.hblank = eb; x.hsync = es; x.le = el; x.tag = tag;
    expQ.push_back(x);
  endtask

  // Reference line: blank outside 0x090..0x1CF, sync inside 0x1E0..0x1EF.
  task automatic modelStep(input logic en);
    if (en) begin
      if (mH == 9'h1FF) begin
        mH = 9'h080; mLe = 1'b1;
      end else begin
        mH = mH + 9'd1; mLe = 1'b0;
      end
      mHb = !(mH >= 9'h090 && mH < 9'h1D0);
      mHs = (mH >= 9'h1E0 && mH < 9'h1F0);
    end else begin
      mLe = 1'b0;
    end
  endtask

  task automatic doReset(input logic en, input string tag);
    mH = 9'h080; mHb = 1'b1; mHs = 1'b0; mLe = 1'b0;
    applyStimulus(1'b1, 1'b0, en, 9'h000, 9'h080, 1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic runModel(input int n, input bit alternate, input string tag);
    logic en;
    for (int k = 0; k < n; k++) begin
      en = alternate ? ((k % 2) == 0) : 1'b1;
      modelStep(en);
      applyStimulus(1'b0, 1'b0, en, 9'h000, mH, mHb, mHs, mLe, tag);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared on the
  // falling edge, well away from the capturing edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".hcnt"},    hcnt,             e.hcnt);
        checkOutput({e.tag, ".hblank"},  {8'b0, hblank},   {8'b0, e.hblank});
        checkOutput({e.tag, ".hsync"},   {8'b0, hsync},    {8'b0, e.hsync});
        checkOutput({e.tag, ".le"},      {8'b0, le},       {8'b0, e.le});
        checkOutput({e.tag, ".hcnt2"},   hcnt2,            e.hcnt);
        checkOutput({e.tag, ".hblank2"}, {8'b0, hblank2},  9'h001);
        checkOutput({e.tag, ".hsync2"},  {8'b0, hsync2},   {8'b0, e.hsync});
        checkOutput({e.tag, ".le2"},     {8'b0, le2},      {8'b0, e.le});
      end
    end
  end

  initial begin
    doReset(1'b0, "reset");
    runModel(384, 1'b0, "freeRun");
    runModel(768, 1'b1, "altEn");
    runModel(383, 1'b0, "toTerm");
    applyStimulus(1'b0, 1'b1, 1'b1, 9'h1E0, 9'h1E0, 1'b1, 1'b1, 1'b0, "ldAtTerm");
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h000, 9'h1E1, 1'b1, 1'b1, 1'b0, "afterLdTerm");

    doReset(1'b0, "reset2");
    runModel(208, 1'b0, "to150");
    doReset(1'b1, "clMidLine");
    runModel(384, 1'b0, "lineAfterCl");

    applyStimulus(1'b1, 1'b1, 1'b1, 9'h123, 9'h080, 1'b1, 1'b0, 1'b0, "resetLdEn");
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h090, 9'h090, 1'b0, 1'b0, 1'b0, "ldHbEnd");
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h090, 9'h090, 1'b0, 1'b0, 1'b0, "ldSame");
    applyStimulus(1'b0, 1'b1, 1'b1, 9'h1E0, 9'h1E0, 1'b0, 1'b1, 1'b0, "ldHsStart");
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h000, 9'h1E0, 1'b0, 1'b1, 1'b0, "hold");
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h1F0, 9'h1F0, 1'b0, 1'b0, 1'b0, "ldHsEnd");
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h1D0, 9'h1D0, 1'b1, 1'b0, 1'b0, "ldHbStart");
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h000, 9'h1D1, 1'b1, 1'b0, 1'b0, "countAfterLd");
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h1FF, 9'h1FF, 1'b1, 1'b0, 1'b0, "ld1FF");
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h000, 9'h1FF, 1'b1, 1'b0, 1'b0, "holdAtTerm");
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h000, 9'h080, 1'b1, 1'b0, 1'b1, "wrapAfterLd");
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h000, 9'h081, 1'b1, 1'b0, 1'b0, "afterWrap");

    #1;
    EN = 1'b0; LD = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hcount_gen.md
HCOUNT_GEN -- requirements
Module: hcount_gen

Interface
REQ-001 SHALL expose parameter LOAD_VAL, default 9'h080: value HCNT takes after terminal count and after reset.
REQ-002 SHALL expose parameter HB_START, default 9'h1D0: HCNT value that sets HBLANK.
REQ-003 SHALL expose parameter HB_END, default 9'h090: HCNT value that clears HBLANK.
REQ-004 SHALL expose parameter HS_START, default 9'h1E0: HCNT value that sets HSYNC.
REQ-005 SHALL expose parameter HS_END, default 9'h1F0: HCNT value that clears HSYNC.
REQ-006 CK  input  1  sole clock; every state element updates on its rising edge only.
REQ-007 CL  input  1  reset; synchronous, active-high.
REQ-008 EN  input  1  pixel clock enable; counting advances only when high.
REQ-009 LD  input  1  synchronous load strobe, active-high.
REQ-010 D  input  9  load value, used when LD is high.
REQ-011 HCNT  output  9  registered horizontal pixel count.
REQ-012 HBLANK  output  1  registered horizontal blank flag.
REQ-013 HSYNC  output  1  registered horizontal sync flag, active-high.
REQ-014 LE  output  1  registered one-cycle line-end pulse; serves as carry/enable into the downstream vertical counter.

Function
REQ-015 Per-edge priority SHALL be CL > LD > (EN and count) > hold.
REQ-016 On LD=1: HCNT <= D; LE <= 0; EN is ignored.
REQ-017 On LD=0, EN=1, HCNT != 9'h1FF: HCNT <= HCNT+1; LE <= 0.
REQ-018 On LD=0, EN=1, HCNT == 9'h1FF: HCNT <= LOAD_VAL, never 9'h000; LE <= 1 for exactly that one cycle.
REQ-019 On LD=0, EN=0: HCNT and both flags hold; LE <= 0.
REQ-020 Flag rule: let N be the value HCNT takes this edge (count, wrap or load). The flag sets if N == its START, clears if N == its END, else holds.
REQ-021 Flags SHALL be evaluated only on edges where HCNT changes or is loaded (REQ-016..018); an LD of the current HCNT value re-applies the rule.
REQ-022 With defaults, the line SHALL be 384 EN cycles: HCNT 0x080..0x1FF, then back to 0x080.
REQ-023 Flags SHALL be combinationally consistent with HCNT in the same cycle: no extra output latency.
REQ-024 If START == END for a flag, set SHALL win.
REQ-025 LD asserted in the same cycle as terminal count (HCNT=0x1FF, EN=1): the load wins, LE stays 0.

Reset
REQ-026 On CL=1 at a CK edge: HCNT=LOAD_VAL, HBLANK=1, HSYNC=0, LE=0, regardless of LD/EN.
REQ-027 CL mid-line SHALL abort the line with no LE pulse; counting resumes from LOAD_VAL on the first EN edge after CL falls.

Structure
REQ-028 Default timing constants (LOAD_VAL, HB_*, HS_*) and the 9'h1FF terminal value SHALL live in a shared video-timing package reused by the vertical counter.
REQ-029 The counter SHALL be built from one sub-module, hcnt_slice: a 4-bit loadable synchronous up-counter with CI/CO carry chain, instantiated 3 times (12 bits, top 3 unused and tied to zero).
REQ-030 Flag and LE logic SHALL live in the top module.

Verification
REQ-031 Reset then EN=1 for 384 cycles -> HCNT steps 0x080..0x1FF, then 0x080; LE high exactly on the cycle HCNT=0x080 after wrap.
REQ-032 Free-run, defaults -> HBLANK falls when HCNT=0x090 and rises at 0x1D0; HSYNC high for HCNT 0x1E0..0x1EF only (16 cycles).
REQ-033 EN toggled 1/0 alternately -> HCNT advances every other cycle; flags and LE never change on EN=0 cycles; line lasts 768 cycles.
REQ-034 HCNT=0x1FF, EN=1, LD=1, D=0x1E0 -> HCNT=0x1E0, LE=0, HSYNC=1.
REQ-035 CL pulsed at HCNT=0x150 with HBLANK=0, HSYNC=0 -> next cycle HCNT=0x080, HBLANK=1, HSYNC=0, LE=0; no LE until a full 384-count line completes.
REQ-036 Parameter override HB_START=HB_END=0x100 -> HBLANK set at 0x100 and never cleared.
